// File: rtl/phase_counter.sv
// phase_counter: loadable up/down modulo counter used as the per-phase timer
// under the traffic-light controller. Counts 0..pMAX_VAL, either wraps or
// freezes at the terminal value, and exposes last/pre_last decodes so the
// controller can prepare the phase hand-over one tick ahead.
module phase_counter #(
  parameter int pMAX_VAL = 99,
  parameter int pCNT_W   = $clog2(pMAX_VAL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [pCNT_W-1:0] load_val,
  input  logic              dir,
  input  logic              hold_mode,
  output logic [pCNT_W-1:0] count,
  output logic              last,
  output logic              pre_last,
  output logic              wrap,
  output logic              done
);

  // Constants sized to the count width so every compare and step stays in
  // pCNT_W bits and never relies on natural binary rollover.
  localparam logic [pCNT_W-1:0] MAX_C  = pCNT_W'(pMAX_VAL);
  localparam logic [pCNT_W-1:0] MAX_M1 = pCNT_W'(pMAX_VAL - 1);
  localparam logic [pCNT_W-1:0] ONE_C  = pCNT_W'(1);
  localparam logic [pCNT_W-1:0] ZERO_C = '0;

  logic [pCNT_W-1:0] terminal;
  logic [pCNT_W-1:0] before_terminal;
  logic [pCNT_W-1:0] load_clamped;
  logic              at_terminal;
  logic [pCNT_W-1:0] count_nxt;
  logic              done_nxt;
  logic              wrap_nxt;

  // Terminal decodes follow the current dir so a direction flip is visible
  // on last/pre_last in the same cycle, before any step happens.
  always_comb begin
    terminal        = dir ? ZERO_C : MAX_C;
    before_terminal = dir ? ONE_C  : MAX_M1;
    at_terminal     = (count == terminal);
    last            = at_terminal;
    pre_last        = (count == before_terminal);
    load_clamped    = (load_val > MAX_C) ? MAX_C : load_val;
  end

  // Next-state selection with priority clr > load > en > hold; the step is
  // only taken away from the terminal, so +1/-1 can never leave 0..pMAX_VAL.
  always_comb begin
    count_nxt = count;
    done_nxt  = done;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = ZERO_C;
      done_nxt  = 1'b0;
    end else if (load) begin
      count_nxt = load_clamped;
      done_nxt  = 1'b0;
    end else if (en) begin
      if (!at_terminal) begin
        count_nxt = dir ? (count - ONE_C) : (count + ONE_C);
      end else if (hold_mode) begin
        done_nxt = 1'b1;
      end else begin
        count_nxt = dir ? MAX_C : ZERO_C;
        wrap_nxt  = 1'b1;
      end
    end
  end

  // State registers; the asynchronous reset wins over everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= ZERO_C;
      done  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      done  <= done_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_phase_counter.sv
// tb_phase_counter: scoreboard bench for phase_counter. Stimulus pushes the
// expected post-edge response into a queue; a monitor pops and compares it on
// every falling edge, against a modular-arithmetic reference model.
module tb_phase_counter;

  localparam int MAX = 99;
  localparam int W   = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         dir = 1'b0;
  logic         hold_mode = 1'b0;
  logic [W-1:0] count;
  logic         last;
  logic         pre_last;
  logic         wrap;
  logic         done;

  typedef struct {
    int count;
    bit wrap;
    bit done;
    bit last;
    bit pre_last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_count = 0;
  bit m_done  = 1'b0;
  bit m_wrap  = 1'b0;

  phase_counter #(.pMAX_VAL(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .dir(dir), .hold_mode(hold_mode),
    .count(count), .last(last), .pre_last(pre_last), .wrap(wrap), .done(done)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge and queue what the
  // outputs must look like at the next falling edge.
  task automatic applyStimulus(input bit rn, input bit c, input bit ld, input int lv,
                               input bit d, input bit hm, input bit e);
    exp_t x;
    int   term;
    @(negedge clk);
    #1;
    rst_n = rn; clr = c; load = ld; load_val = W'(lv);
    dir = d; hold_mode = hm; en = e;
    term = d ? 0 : MAX;
    if (!rn) begin
      m_count = 0; m_done = 0; m_wrap = 0;
    end else if (c) begin
      m_count = 0; m_done = 0; m_wrap = 0;
    end else if (ld) begin
      m_count = (lv > MAX) ? MAX : lv; m_done = 0; m_wrap = 0;
    end else if (e) begin
      if (m_count == term && hm) begin
        m_done = 1; m_wrap = 0;
      end else begin
        m_wrap  = (m_count == term);
        m_count = (m_count + (d ? MAX : 1)) % (MAX + 1);
      end
    end else begin
      m_wrap = 0;
    end
    x.count    = m_count;
    x.wrap     = m_wrap;
    x.done     = m_done;
    x.last     = (m_count == term);
    x.pre_last = (m_count == (d ? 1 : MAX - 1));
    exp_q.push_back(x);
  endtask

  // Assert reset in the middle of a cycle and confirm it acts before any edge.
  task automatic applyAsyncReset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    m_count = 0; m_done = 0; m_wrap = 0;
    #1;
    checkOutput("async_count", int'(count), 0);
    checkOutput("async_done", int'(done), 0);
    checkOutput("async_wrap", int'(wrap), 0);
  endtask

  // Monitor: compare the DUT against each queued expectation at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("count", int'(count), e.count);
        checkOutput("wrap", int'(wrap), int'(e.wrap));
        checkOutput("done", int'(done), int'(e.done));
        checkOutput("last", int'(last), int'(e.last));
        checkOutput("pre_last", int'(pre_last), int'(e.pre_last));
      end
    end
  end

  initial begin
    int wait_cycles;
    bit r_dir;
    bit r_hm;

    // Reset held for a few cycles, both directions, then a full up-wrap run
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 105; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1);

    // Load 5, count down in hold mode to a frozen 0 with done
    applyStimulus(1, 0, 1, 5, 1, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 1, 1, 1);

    // Clamped load, load beating en, clr beating load
    applyStimulus(1, 0, 1, 120, 0, 0, 0);
    applyStimulus(1, 0, 1, 10, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 1, 40, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Count up to 50, then flip direction with en held
    for (int i = 0; i < 50; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 1, 0, 1);

    // Reach done in hold mode, drop hold_mode to resume wrapping, climb to 73
    applyStimulus(1, 0, 1, 98, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 74; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyAsyncReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1);

    // en every other cycle over more than a full range in each direction
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 210; i++) applyStimulus(1, 0, 0, 0, 0, 0, (i % 2) == 0);
    for (int i = 0; i < 210; i++) applyStimulus(1, 0, 0, 0, 1, 0, (i % 2) == 1);

    // Randomised mix of every control
    r_dir = 0;
    r_hm  = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) r_dir = ~r_dir;
      if ($urandom_range(0, 29) == 0) r_hm = ~r_hm;
      applyStimulus($urandom_range(0, 199) != 0,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 24) == 0,
                    int'($urandom_range(0, 127)),
                    r_dir, r_hm,
                    $urandom_range(0, 3) != 0);
    end

    // Let the monitor drain the queue within a bounded number of cycles
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
